// File: rtl/lll_pkg.sv
// Shared types and helpers for the lll write engine.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package lll_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GETW,
    CHK,
    ISSUE,
    WRSP,
    DONE
  } lll_wr_state_e;

  localparam int LLL_MAX_WCNT = 4;

  // A byte plus its parity bit must carry an odd number of ones.
  function automatic logic odd_par_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/lll_par_chk.sv
// Per-byte odd-parity check over one write word.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module lll_par_chk
  import lll_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0]   data,
  input  logic [DATA_W/8-1:0] par,
  output logic                par_ok
);

  // One bad byte anywhere makes the whole word bad.
  always_comb begin
    par_ok = 1'b1;
    for (int b = 0; b < DATA_W/8; b++) begin
      if (!odd_par_ok(data[8*b +: 8], par[b])) par_ok = 1'b0;
    end
  end

endmodule

// File: rtl/lll_write_engine.sv
// Burst write responder: takes 1..MAX_WCNT parity-checked words, one memory write each.
// Latency: 4 cycles per word with immediate gnt/rvalid; 1-word burst start-to-done 5 cycles.
// Backpressure: lll_dready only in GETW; mem_req held until mem_gnt; one write outstanding.
module lll_write_engine
  import lll_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int MAX_WCNT = LLL_MAX_WCNT,
  parameter int TMO_CYC  = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                lll_start,
  input  logic [2:0]          lll_wcnt,
  input  logic [ADDR_W-1:0]   lll_addr,
  input  logic                lll_dvalid,
  output logic                lll_dready,
  input  logic [DATA_W-1:0]   lll_data,
  input  logic [DATA_W/8-1:0] lll_par,
  output logic                lll_done,
  output logic                lll_err,
  output logic                lll_busy,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic                mem_rerr
);

  lll_wr_state_e         state, state_nxt;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     data_q;
  logic [DATA_W/8-1:0]   par_q;
  logic [2:0]            rem_q;
  logic [7:0]            tmr_q;
  logic                  err_q;
  logic                  par_ok;
  logic                  wcnt_ok;
  logic                  tmo_hit;

  lll_par_chk #(.DATA_W(DATA_W)) u_par_chk (
    .data   (data_q),
    .par    (par_q),
    .par_ok (par_ok)
  );

  assign wcnt_ok = (lll_wcnt != 3'd0) && (lll_wcnt <= 3'(MAX_WCNT));
  // A response arriving on the expiry cycle is checked first, so it wins.
  assign tmo_hit = (tmr_q == 8'(TMO_CYC));

  // State register; reset abandons any burst without a done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (lll_start) state_nxt = wcnt_ok ? GETW : DONE;
      GETW:    if (lll_dvalid) state_nxt = CHK;
      CHK:     state_nxt = par_ok ? ISSUE : DONE;
      ISSUE:   if (mem_gnt) state_nxt = WRSP;
      WRSP: begin
        if (mem_rvalid) begin
          if (mem_rerr || rem_q == 3'd1) state_nxt = DONE;
          else                           state_nxt = GETW;
        end else if (tmo_hit) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Burst datapath: address/word-count tracking, word capture, timer and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      data_q <= '0;
      par_q  <= '0;
      rem_q  <= '0;
      tmr_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lll_start) begin
            if (wcnt_ok) begin
              addr_q <= lll_addr;
              rem_q  <= lll_wcnt;
              err_q  <= 1'b0;
            end else begin
              err_q  <= 1'b1;
            end
          end
        end
        GETW: begin
          if (lll_dvalid) begin
            data_q <= lll_data;
            par_q  <= lll_par;
          end
        end
        CHK: begin
          if (!par_ok) err_q <= 1'b1;
        end
        ISSUE: begin
          if (mem_gnt) tmr_q <= '0;
        end
        WRSP: begin
          if (mem_rvalid) begin
            if (mem_rerr) begin
              err_q <= 1'b1;
            end else begin
              addr_q <= addr_q + ADDR_W'(DATA_W/8);
              rem_q  <= rem_q - 3'd1;
            end
          end else if (tmo_hit) begin
            err_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign lll_dready = (state == GETW);
  assign lll_done   = (state == DONE);
  assign lll_busy   = (state != IDLE);
  assign lll_err    = err_q;
  assign mem_req    = (state == ISSUE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = data_q;

endmodule

// File: tb/tb_lll_write_engine.sv
// Directed bench for lll_write_engine: each scenario is expanded into a per-cycle timeline
// of stimulus and expected outputs from the burst rules, then replayed against the DUT.
// A single negedge compare process checks every cycle of every scenario.
module tb_lll_write_engine;
  localparam int N   = 600;
  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        lll_start, lll_dvalid, lll_dready, lll_done, lll_err, lll_busy;
  logic [2:0]  lll_wcnt;
  logic [31:0] lll_addr, mem_addr;
  logic [63:0] lll_data, mem_wdata;
  logic [7:0]  lll_par;
  logic        mem_req, mem_gnt, mem_rvalid, mem_rerr;

  lll_write_engine dut (
    .clk(clk), .reset_n(reset_n), .lll_start(lll_start), .lll_wcnt(lll_wcnt),
    .lll_addr(lll_addr), .lll_dvalid(lll_dvalid), .lll_dready(lll_dready),
    .lll_data(lll_data), .lll_par(lll_par), .lll_done(lll_done), .lll_err(lll_err),
    .lll_busy(lll_busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rerr(mem_rerr)
  );

  always #5 clk = ~clk;

  // Scenario timeline: stimulus (s_*) and expected outputs (e_*) per cycle.
  bit          s_start[N], s_dvalid[N], s_gnt[N], s_rvalid[N], s_rerr[N];
  logic [63:0] s_data[N];
  logic [7:0]  s_par[N];
  logic [2:0]  s_wcnt_v;
  logic [31:0] s_addr_v;
  bit          e_busy[N], e_dready[N], e_req[N], e_done[N], e_err[N];
  logic [31:0] e_addr[N];
  logic [63:0] e_wdata[N];

  // Per-word knobs: data delay, bad byte (-1 none), gnt delay, response kind
  // (0 ok, 1 error, 2 none), response delay after gnt.
  int w_dv[4], w_bad[4], w_gd[4], w_rsp[4], w_rd[4];

  int   m_done, slen, cyc;
  bit   err_prev;
  bit   chk_en, chk_rst;
  int   n_tests, n_fail;
  logic [31:0] wr_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic clr_words();
    for (int i = 0; i < 4; i++) begin
      w_dv[i] = 0; w_bad[i] = -1; w_gd[i] = 0; w_rsp[i] = 0; w_rd[i] = 0;
    end
  endtask

  task automatic set_word(input int i, input int dv, input int bad, input int gd,
                          input int rsp, input int rd);
    w_dv[i] = dv; w_bad[i] = bad; w_gd[i] = gd; w_rsp[i] = rsp; w_rd[i] = rd;
  endtask

  // Lay out the burst on a cycle axis: cycle 0 is the start pulse.
  task automatic build(input int wcnt, input logic [31:0] base);
    int g, acc, iss, gc, ws, rc, t;
    logic [31:0] a;
    logic [63:0] d;
    logic [7:0]  p;
    bit fin_err;
    for (int k = 0; k < N; k++) begin
      s_start[k] = 0; s_dvalid[k] = 0; s_gnt[k] = 0; s_rvalid[k] = 0; s_rerr[k] = 0;
      s_data[k] = '0; s_par[k] = '0;
      e_busy[k] = 0; e_dready[k] = 0; e_req[k] = 0; e_done[k] = 0; e_err[k] = err_prev;
      e_addr[k] = '0; e_wdata[k] = '0;
    end
    s_wcnt_v = wcnt[2:0];
    s_addr_v = base;
    s_start[0] = 1;
    fin_err = 0;
    m_done = -1;
    if (wcnt < 1 || wcnt > 4) begin
      m_done = 1; fin_err = 1;
    end else begin
      t = 0; a = base;
      for (int i = 0; i < wcnt && m_done < 0; i++) begin
        g = t + 1; acc = g + w_dv[i];
        for (int c = g; c <= acc; c++) e_dready[c] = 1;
        d = {32'hC0DE_0000 | 32'(i), a ^ 32'h5A5A_A5A5};
        for (int b = 0; b < 8; b++) p[b] = ~^d[8*b +: 8];
        if (w_bad[i] >= 0) p[w_bad[i]] = ~p[w_bad[i]];
        s_dvalid[acc] = 1; s_data[acc] = d; s_par[acc] = p;
        if (w_bad[i] >= 0) begin
          m_done = acc + 2; fin_err = 1;
        end else begin
          iss = acc + 2; gc = iss + w_gd[i];
          for (int c = iss; c <= gc; c++) begin
            e_req[c] = 1; e_addr[c] = a; e_wdata[c] = d;
            if (c < gc && w_rsp[i] != 2) begin s_rvalid[c] = 1; s_rerr[c] = 1; end
          end
          s_gnt[gc] = 1;
          ws = gc + 1;
          rc = ws + ((w_rsp[i] == 2) ? TMO : w_rd[i]);
          if (w_rsp[i] != 2) begin s_rvalid[rc] = 1; s_rerr[rc] = (w_rsp[i] == 1); end
          if (w_rsp[i] != 0) begin m_done = rc + 1; fin_err = 1; end
          else if (i == wcnt - 1) m_done = rc + 1;
          a = a + 32'd8; t = rc;
        end
      end
    end
    for (int c = 1; c <= m_done; c++) e_busy[c] = 1;
    for (int c = 1; c < m_done; c++) e_err[c] = 0;
    for (int c = m_done; c < N; c++) e_err[c] = fin_err;
    e_done[m_done] = 1;
    err_prev = fin_err;
    slen = m_done + 3;
  endtask

  task automatic drive_idle();
    lll_start = 0; lll_wcnt = '0; lll_addr = '0; lll_dvalid = 0; lll_data = '0;
    lll_par = '0; mem_gnt = 0; mem_rvalid = 0; mem_rerr = 0;
  endtask

  task automatic run_scn(input int lim);
    for (int k = 0; k < lim; k++) begin
      @(posedge clk); #1;
      cyc = k; chk_en = 1;
      lll_start = s_start[k]; lll_wcnt = s_wcnt_v; lll_addr = s_addr_v;
      lll_dvalid = s_dvalid[k]; lll_data = s_data[k]; lll_par = s_par[k];
      mem_gnt = s_gnt[k]; mem_rvalid = s_rvalid[k]; mem_rerr = s_rerr[k];
      @(negedge clk);
    end
    chk_en = 0;
  endtask

  // Compare process: every cycle of a scenario, and every cycle held in reset.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",   64'(lll_busy),   64'(e_busy[cyc]));
      chk("dready", 64'(lll_dready), 64'(e_dready[cyc]));
      chk("req",    64'(mem_req),    64'(e_req[cyc]));
      chk("done",   64'(lll_done),   64'(e_done[cyc]));
      chk("err",    64'(lll_err),    64'(e_err[cyc]));
      if (e_req[cyc]) begin
        chk("addr",  64'(mem_addr), 64'(e_addr[cyc]));
        chk("wdata", mem_wdata,     e_wdata[cyc]);
      end
      if (mem_req && mem_gnt) wr_q.push_back(mem_addr);
    end
    if (chk_rst) begin
      chk("rst_outs", {lll_dready, lll_done, lll_err, lll_busy, mem_req}, 64'd0);
      chk("rst_addr", 64'(mem_addr), 64'd0);
      chk("rst_wdata", mem_wdata, 64'd0);
    end
  end

  initial begin
    n_tests = 0; n_fail = 0; chk_en = 0; chk_rst = 0; err_prev = 0; cyc = 0;
    reset_n = 0;
    drive_idle();
    @(posedge clk); #1; chk_rst = 1;
    @(negedge clk); @(negedge clk); #1; chk_rst = 0;
    @(posedge clk); #1 reset_n = 1;

    // Three back-to-back words, best case: writes at 0x100, 0x108, 0x110.
    clr_words();
    build(3, 32'h100);
    chk("pin_done_3w", 64'(m_done), 64'd13);
    wr_q.delete();
    run_scn(slen);
    chk("wr_count_3w", 64'(wr_q.size()), 64'd3);
    if (wr_q.size() == 3) begin
      chk("wr0", 64'(wr_q[0]), 64'h100);
      chk("wr1", 64'(wr_q[1]), 64'h108);
      chk("wr2", 64'(wr_q[2]), 64'h110);
    end

    // Illegal word counts: immediate done with error, no memory traffic.
    clr_words();
    build(0, 32'h200);
    chk("pin_done_wcnt0", 64'(m_done), 64'd1);
    run_scn(slen);
    build(5, 32'h200);
    run_scn(slen);

    // Second word of four has a bad byte 3; a stray start mid-burst is ignored.
    clr_words();
    set_word(0, 2, -1, 0, 0, 0);
    set_word(1, 1, 3, 0, 0, 0);
    build(4, 32'h4000);
    s_start[4] = 1;
    chk("pin_done_par", 64'(m_done), 64'd10);
    wr_q.delete();
    run_scn(slen);
    chk("wr_count_par", 64'(wr_q.size()), 64'd1);

    // Write error on word one of two aborts the second word.
    clr_words();
    set_word(0, 0, -1, 0, 1, 3);
    build(2, 32'h800);
    s_start[2] = 1;
    wr_q.delete();
    run_scn(slen);
    chk("wr_count_rerr", 64'(wr_q.size()), 64'd1);

    // Address wrap with gnt/response/data delays and ignored stray responses in ISSUE.
    clr_words();
    set_word(0, 0, -1, 2, 0, 4);
    set_word(1, 3, -1, 1, 0, 0);
    build(2, 32'hFFFF_FFF8);
    wr_q.delete();
    run_scn(slen);
    chk("wr_count_wrap", 64'(wr_q.size()), 64'd2);
    if (wr_q.size() == 2) chk("wrap_addr", 64'(wr_q[1]), 64'h0);

    // Delayed gnt then no response: timeout error. Then response on the expiry cycle.
    clr_words();
    set_word(0, 0, -1, 10, 2, 0);
    build(1, 32'h40);
    chk("pin_done_tmo", 64'(m_done), 64'd270);
    run_scn(slen);
    clr_words();
    set_word(0, 0, -1, 10, 0, TMO);
    build(1, 32'h48);
    chk("pin_err_late_ok", 64'(err_prev), 64'd0);
    run_scn(slen);

    // Reset while waiting for the response, then a clean single-word burst.
    clr_words();
    set_word(0, 0, -1, 0, 2, 0);
    build(1, 32'h300);
    run_scn(8);
    @(posedge clk); #1;
    reset_n = 0; drive_idle(); mem_rvalid = 1; chk_rst = 1;
    @(negedge clk); @(negedge clk); #1;
    chk_rst = 0; mem_rvalid = 0;
    @(posedge clk); #1 reset_n = 1;
    err_prev = 0;
    clr_words();
    build(1, 32'h308);
    chk("pin_done_1w", 64'(m_done), 64'd5);
    run_scn(slen);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
